// File: rtl/montgomery_to_mont_if.sv
// Start/valid handshake bundle between a requester and montgomery_to_mont.
// master drives the operands, slave (the converter) returns the result.
interface montgomery_to_mont_if #(
  parameter int WIDTH = 64
);
  logic             start_i;
  logic [WIDTH-1:0] y_i;
  logic [WIDTH-1:0] m_i;
  logic [WIDTH-1:0] m_bl_i;
  logic [WIDTH-1:0] result_o;
  logic             valid_o;
  logic             busy_o;
  logic             err_o;

  modport master (
    output start_i, y_i, m_i, m_bl_i,
    input  result_o, valid_o, busy_o, err_o
  );

  modport slave (
    input  start_i, y_i, m_i, m_bl_i,
    output result_o, valid_o, busy_o, err_o
  );
endinterface

// File: rtl/montgomery_to_mont.sv
// Serial y*2^k mod m converter, one shift/conditional-subtract per cycle.
// Optional operand range check: define MONT_TO_MONT_RANGE_CHECK_EN.
module montgomery_to_mont #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  montgomery_to_mont_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] r, m, result;
  logic [CNT_W-1:0] cnt;
  logic             err;

  logic [CNT_W-1:0] cnt_init;
  logic [WIDTH-1:0] t, r_step;
  logic             range_bad;
  logic             valid, busy;

  assign cnt_init = bus.m_bl_i[CNT_W-1:0];

  // r < m < 2^(WIDTH-1) keeps the doubled value inside WIDTH bits.
  assign t      = {r[WIDTH-2:0], 1'b0};
  assign r_step = (t >= m) ? (t - m) : t;

`ifdef MONT_TO_MONT_RANGE_CHECK_EN
  assign range_bad = ~bus.m_i[0] || (bus.m_i == '0) || (bus.y_i >= bus.m_i) ||
                     bus.m_i[WIDTH-1] || (bus.m_bl_i > WIDTH'(WIDTH - 1));
`else
  assign range_bad = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.m_bl_i[WIDTH-1:CNT_W], r[WIDTH-1]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i)
          state_nxt = (range_bad || cnt_init == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        valid     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // result only moves on entry to DONE so it stays put for late consumers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r      <= '0;
      m      <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            r   <= bus.y_i;
            m   <= bus.m_i;
            cnt <= cnt_init;
            err <= range_bad;
            if (range_bad)             result <= '0;
            else if (cnt_init == '0)   result <= bus.y_i;
          end
        end
        SHIFT: begin
          r   <= r_step;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) result <= r_step;
        end
        DONE:    err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.valid_o  = valid;
  assign bus.busy_o   = busy;
  assign bus.err_o    = err && valid;
endmodule

// File: tb/tb_montgomery_to_mont.sv
// Directed vector bench for montgomery_to_mont: table of conversions plus
// reset, held-start and back-to-back sequences.
module tb_montgomery_to_mont;
  localparam int W = 64;
  localparam logic [W-1:0] DIL = 64'h7FE001;
  localparam logic [W-1:0] KYB = 64'hD01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  montgomery_to_mont_if #(.WIDTH(W)) bus ();
  montgomery_to_mont #(.WIDTH(W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;
  int err_hi = 0;

  always @(negedge clk) if (bus.err_o) err_hi++;

  typedef struct {
    logic [W-1:0] y;
    logic [W-1:0] m;
    int           k;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_conv(input logic [W-1:0] y, input logic [W-1:0] m, input int k,
                          output logic [W-1:0] res, output int lat, output int bcnt,
                          output logic errv);
    @(negedge clk);
    bus.start_i = 1'b1; bus.y_i = y; bus.m_i = m; bus.m_bl_i = W'(k);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    lat = 0; bcnt = 0; res = '0; errv = 1'b0;
    while (lat < 200) begin
      lat++;
      @(negedge clk);
      if (bus.busy_o) bcnt++;
      if (bus.valid_o) begin
        res  = bus.result_o;
        errv = bus.err_o;
        break;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    logic [W-1:0] res;
    int lat, bcnt, pulses, bad, last;
    logic errv;

    vecs[0] = '{64'h1,      DIL,   23, 64'h1FFF};
    vecs[1] = '{64'h7FE000, DIL,   23, 64'h7FC002};
    vecs[2] = '{64'h0,      DIL,   23, 64'h0};
    vecs[3] = '{64'h1,      KYB,   12, 64'h2FF};
    vecs[4] = '{64'h2,      KYB,   12, 64'h5FE};
    vecs[5] = '{64'hD00,    KYB,   12, 64'hA02};
    vecs[6] = '{64'h5,      64'd7,  0, 64'h5};
    vecs[7] = '{64'h5,      64'd13, 3, 64'h1};
    vecs[8] = '{64'h123,    KYB,    1, 64'h246};
    vecs[9] = '{64'h800,    KYB,    1, 64'h2FF};

    bus.start_i = 1'b0; bus.y_i = '0; bus.m_i = '0; bus.m_bl_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset result", bus.result_o, '0);
    check("reset valid",  W'(bus.valid_o), '0);
    check("reset busy",   W'(bus.busy_o), '0);
    check("reset err",    W'(bus.err_o), '0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].y, vecs[i].m, vecs[i].k, res, lat, bcnt, errv);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), W'(lat), W'(vecs[i].k + 1));
      check($sformatf("vec%0d busy cycles", i), W'(bcnt), W'(vecs[i].k + 1));
      check($sformatf("vec%0d err", i), W'(errv), '0);
      @(negedge clk);
      check($sformatf("vec%0d valid after", i), W'(bus.valid_o), '0);
      check($sformatf("vec%0d busy after", i), W'(bus.busy_o), '0);
      check($sformatf("vec%0d result held", i), bus.result_o, vecs[i].exp);
    end

    // start held two cycles: only one conversion
    @(negedge clk);
    bus.start_i = 1'b1; bus.y_i = 64'h1; bus.m_i = KYB; bus.m_bl_i = 64'd12;
    repeat (2) @(posedge clk);
    #1 bus.start_i = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.valid_o) pulses++;
    end
    check("held start pulses", W'(pulses), W'(1));
    check("held start result", bus.result_o, 64'h2FF);

    // reset in the middle of a Dilithium conversion
    @(negedge clk);
    bus.start_i = 1'b1; bus.y_i = 64'h1; bus.m_i = DIL; bus.m_bl_i = 64'd23;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst busy",   W'(bus.busy_o), '0);
    check("midrst valid",  W'(bus.valid_o), '0);
    check("midrst result", bus.result_o, '0);
    rst_n = 1'b1;
    run_conv(64'h1, DIL, 23, res, lat, bcnt, errv);
    check("post-reset result", res, 64'h1FFF);
    check("post-reset latency", W'(lat), W'(24));

    // back-to-back with start held: k=0 (period 2) and k=3 (period 5)
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.y_i = 64'h5; bus.m_i = (p == 0) ? 64'd7 : 64'd13; bus.m_bl_i = (p == 0) ? 64'd0 : 64'd3;
      pulses = 0; bad = 0; last = -1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.valid_o) begin
          pulses++;
          if (last >= 0 && c - last != ((p == 0) ? 2 : 5)) bad++;
          if (bus.result_o !== ((p == 0) ? 64'h5 : 64'h1)) bad++;
          last = c;
        end
      end
      bus.start_i = 1'b0;
      check($sformatf("b2b%0d pulses", p), W'(pulses), (p == 0) ? W'(20) : W'(8));
      check($sformatf("b2b%0d spacing/result errors", p), W'(bad), '0);
      repeat (8) @(posedge clk);
    end

`ifdef MONT_TO_MONT_RANGE_CHECK_EN
    run_conv(64'hD01, KYB, 12, res, lat, bcnt, errv);
    check("range err flag", W'(errv), W'(1));
    check("range err result", res, '0);
    check("range err latency", W'(lat), W'(1));
    @(negedge clk);
    check("range err clears", W'(bus.err_o), '0);
    run_conv(64'h1, KYB, 12, res, lat, bcnt, errv);
    check("range ok err", W'(errv), '0);
    check("range ok result", res, 64'h2FF);
`else
    check("err never raised", W'(err_hi), '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/montgomery_to_mont.md
# montgomery_to_mont

Serial converter that maps an operand into the Montgomery domain by computing y·2^k mod m, with k = m_bl_i. It sits directly upstream of `montgomery_serialized` and produces that block's `y_i` operand (y·R mod m, R = 2^m_bl) from a plain residue. It uses one shift/conditional-subtract step per cycle. Its ports mirror the multiplier's start/valid handshake so the two blocks chain without glue.

## Interface
- `WIDTH`, default 64: datapath width of y, m and result.
- `CNT_W`, default $clog2(WIDTH)+1: iteration counter width.
- `clk_i`  in  1: clock, rising edge active.
- `rst_ni`  in  1: reset. One clock; reset is synchronous and active-low.
- `start_i`  in  1: start request, sampled only in IDLE.
- `y_i`  in  WIDTH: operand, plain residue.
- `m_i`  in  WIDTH: modulus (odd).
- `m_bl_i`  in  WIDTH: iteration count k, normally $clog2(m); the low CNT_W bits are used.
- `result_o`  out  WIDTH: y·2^k mod m.
- `valid_o`  out  1: single-cycle result-valid pulse.
- `busy_o`  out  1: high in SHIFT and DONE.
- `err_o`  out  1: range error flag. Tied 0 unless the macro in Configuration is defined.

## Operation
- Preconditions (unchecked by default):
  - m_i < 2^(WIDTH-1), so 2r fits in WIDTH bits.
  - y_i < m_i.
  - 1 ≤ m_bl_i ≤ WIDTH-1, or m_bl_i = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE with start_i=1 at a clock edge:
  - Latch r←y_i, m←m_i, cnt←m_bl_i[CNT_W-1:0].
  - Next state is SHIFT if cnt≠0, else DONE.
- SHIFT, each edge:
  - t = r<<1; r ← (t ≥ m) ? t−m : t; cnt ← cnt−1.
  - When cnt==1 before the step, go to DONE.
- DONE:
  - valid_o=1 and result_o=r for exactly one cycle, then return to IDLE.
- start_i is ignored outside IDLE.
  - A start held across several cycles is taken once per IDLE visit.
  - A start still high on the first IDLE cycle after DONE begins a new conversion.
- result_o holds its last value until the next conversion completes.
  - It is not cleared on the DONE→IDLE transition.
- Invariant: r < m after every step. No modular result ever equals or exceeds m.

## Timing
- Reset: any edge with rst_ni=0 forces IDLE regardless of state, including mid-SHIFT.
  - result_o=0, valid_o=0, busy_o=0, err_o=0, cnt=0.
- Latency: start sampled at edge E0 gives valid_o=1 in the cycle after edge E0+k (observed at edge E0+k+1).
  - Example: Dilithium, k=23 gives 24 edges. Kyber, k=12 gives 13 edges.
  - k=0 gives valid in the cycle after E0, with result = y.
- busy_o rises the cycle after E0 and falls together with valid_o.
- Throughput: one conversion per k+2 cycles when start_i is held high.
- Downstream rule: result_o is stable while valid_o=1 and stays stable afterwards. The consumer may sample it at or after the valid edge.

## Configuration
- `MONT_TO_MONT_RANGE_CHECK_EN`.
- Defined: in IDLE on start, the block checks for m_i even, m_i=0, y_i ≥ m_i, m_i ≥ 2^(WIDTH-1), or m_bl_i > WIDTH-1.
  - On any violation it goes straight to DONE with result_o=0 and err_o=1 for the valid cycle.
  - err_o=0 on every other cycle.
- Not defined: no checks are made, err_o is constant 0, and out-of-range inputs give undefined results.

## Test plan
- Dilithium: m=0x7FE001, k=23, y=1 → result 0x001FFF, valid 24 edges after start, busy high 24 cycles.
- Dilithium: y=0x7FE000 (m−1) → 0x7FC002. y=0 → 0x000000.
- Kyber: m=0xD01, k=12. y=1 → 0x2FF, y=2 → 0x5FE, valid 13 edges after start. start_i held 2 cycles → exactly one valid pulse.
- Reset mid-op: start Dilithium y=1, drop rst_ni at edge 10 → next cycle busy_o=0, valid_o=0, result_o=0. New start afterwards gives the correct 0x1FFF.
- k=0: m=7, y=5, m_bl=0 → result 5, valid one edge after start. Back-to-back starts with start_i held high each give one pulse per k+2 cycles.
- With MONT_TO_MONT_RANGE_CHECK_EN: m=0xD01, y=0xD01 → valid one edge after start, err_o=1, result 0. Then y=1 → err_o=0, result 0x2FF.
